// File: rtl/processor_multicycle_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset core: opcodes, FSM states,
// ALU control and immediate-select codes, and the control bundle.
package processor_multicycle_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_DATA   = 2'b01,
    WB_PC     = 2'b10
  } wb_src_e;

  typedef struct packed {
    logic      mem_req;
    logic      mem_we;
    logic      addr_alu;   // mem_addr from ALUOut instead of PC
    logic      ir_we;      // also captures OldPC
    logic      pc_we;
    logic      pc_alu;     // PC <= ALUOut instead of PC+4
    logic      ab_we;
    logic      aluout_we;
    logic      srca_pc;    // ALU A operand is OldPC
    logic      srcb_imm;
    alu_ctrl_e alu_ctrl;
    imm_src_e  imm_src;
    logic      data_we;
    logic      rf_we;
    wb_src_e   wb_src;
    logic      retire;
    logic      halted;
  } ctrl_t;

  // ALUOp 00 = add, 01 = sub, otherwise decoded from funct3/funct7.
  function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [2:0] funct3,
                                           input logic op5, input logic funct7b5);
    alu_ctrl_e ctl;
    ctl = ALU_ADD;
    case (alu_op)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      default: begin
        case (funct3)
          3'b000:  ctl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  ctl = ALU_SLT;
          3'b110:  ctl = ALU_OR;
          3'b111:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/processor_multicycle_control.sv
// Control FSM of the multi-cycle core: sequences FETCH..writeback and emits
// the datapath enables/selects as one ctrl_t bundle.
module processor_multicycle_control
  import processor_multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       mem_ready,
  input  logic       a_eq_b,
  output ctrl_t      ctrl
);

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ctrl          = '0;
    ctrl.alu_ctrl = ALU_ADD;
    ctrl.imm_src  = IMM_I;
    ctrl.wb_src   = WB_ALUOUT;
    state_d       = state_q;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed here so BEQ/JAL need one cycle.
        ctrl.ab_we     = 1'b1;
        ctrl.aluout_we = 1'b1;
        ctrl.srca_pc   = 1'b1;
        ctrl.srcb_imm  = 1'b1;
        ctrl.imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl.aluout_we = 1'b1;
        ctrl.srcb_imm  = 1'b1;
        ctrl.imm_src   = (opcode == OP_SW) ? IMM_S : IMM_I;
        state_d        = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.addr_alu = 1'b1;
        if (mem_ready) begin
          ctrl.data_we = 1'b1;
          state_d      = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_src = WB_DATA;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_we   = 1'b1;
        ctrl.addr_alu = 1'b1;
        if (mem_ready) begin
          ctrl.retire = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXECR: begin
        ctrl.aluout_we = 1'b1;
        ctrl.alu_ctrl  = alu_decode(2'b10, funct3, opcode[5], funct7b5);
        state_d        = S_ALUWB;
      end
      S_EXECI: begin
        ctrl.aluout_we = 1'b1;
        ctrl.srcb_imm  = 1'b1;
        ctrl.alu_ctrl  = alu_decode(2'b10, funct3, opcode[5], funct7b5);
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.rf_we  = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        ctrl.pc_we  = a_eq_b;
        ctrl.pc_alu = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        ctrl.rf_we  = 1'b1;
        ctrl.wb_src = WB_PC;
        ctrl.pc_we  = 1'b1;
        ctrl.pc_alu = 1'b1;
        ctrl.retire = 1'b1;
        state_d     = S_FETCH;
      end
      S_TRAP:  ctrl.halted = 1'b1;
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: rtl/processor_multicycle.sv
// Multi-cycle RV32I-subset core on a single req/ready memory port; datapath
// (extend, ALU, register file) widened to XLEN, sequencing in the control FSM.
module processor_multicycle
  import processor_multicycle_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] alu_result,
  output logic            retire,
  output logic            halted
);

  ctrl_t ctrl;

  logic [XLEN-1:0] pc_q, pc_d, oldpc_q, oldpc_d, a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] aluout_q, aluout_d, data_q, data_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] rf_q [32];

  logic [4:0]      rs1, rs2, rd;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, src_a, src_b, alu_y, wb_val;

  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign rd  = ir_q[11:7];

  processor_multicycle_control u_ctrl (
    .clk       (clk),
    .rst_n     (reset),
    .opcode    (ir_q[6:0]),
    .funct3    (ir_q[14:12]),
    .funct7b5  (ir_q[30]),
    .mem_ready (mem_ready),
    .a_eq_b    (a_q == b_q),
    .ctrl      (ctrl)
  );

  always_comb begin
    case (ctrl.imm_src)
      IMM_S:   imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
      IMM_B:   imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
      IMM_J:   imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
      default: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
    endcase
    imm = XLEN'($signed(imm32));
  end

  assign rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];

  assign src_a = ctrl.srca_pc  ? oldpc_q : a_q;
  assign src_b = ctrl.srcb_imm ? imm     : b_q;

  always_comb begin
    case (ctrl.alu_ctrl)
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_y = src_a + src_b;
    endcase
  end

  // In JAL, PC already holds OldPC+4 (advanced in FETCH), so it is the link value.
  always_comb begin
    case (ctrl.wb_src)
      WB_DATA: wb_val = data_q;
      WB_PC:   wb_val = pc_q;
      default: wb_val = aluout_q;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    oldpc_d  = oldpc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    data_d   = data_q;
    if (ctrl.ir_we) begin
      ir_d    = mem_rdata[31:0];
      oldpc_d = pc_q;
    end
    if (ctrl.pc_we)     pc_d = ctrl.pc_alu ? aluout_q : pc_q + XLEN'(4);
    if (ctrl.ab_we) begin
      a_d = rs1_val;
      b_d = rs2_val;
    end
    if (ctrl.aluout_we) aluout_d = alu_y;
    if (ctrl.data_we)   data_d   = mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      data_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      oldpc_q  <= oldpc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
      data_q   <= data_d;
    end
  end

  // Register file is intentionally not reset; x0 is forced to zero on read.
  always_ff @(posedge clk) begin
    if (ctrl.rf_we && rd != 5'd0) rf_q[rd] <= wb_val;
  end

  // Gating with reset drops a pending request in the same cycle reset asserts.
  assign mem_req    = reset & ctrl.mem_req;
  assign mem_we     = reset & ctrl.mem_we;
  assign mem_addr   = ctrl.addr_alu ? aluout_q : pc_q;
  assign mem_wdata  = b_q;
  assign pc_out     = pc_q;
  assign alu_result = aluout_q;
  assign retire     = ctrl.retire;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_processor_multicycle.sv
// Self-checking bench: instruction vectors with expected cycle counts, stores
// and next PC, plus hand sequences for trap and reset during a stalled store.
module tb_processor_multicycle;
  import processor_multicycle_pkg::*;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_out, alu_result;

  processor_multicycle #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .pc_out     (pc_out),
    .alu_result (alu_result),
    .retire     (retire),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  typedef struct {
    string       name;
    logic [31:0] instr;
    int          waits;
    int          cycles;
    bit          has_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] next_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        vecs[$];
  wr_t         wr_q[$];
  int          ret_q[$];
  int          nvec, nerr, cyc, waits, wleft;
  bit          in_txn, prev_stall, retired;
  logic [31:0] snap_addr, snap_wdata, snap_ctl, exp_pc;

  function automatic logic [31:0] enc_r(input int f7, input int r2, input int r1, input int f3, input int rd);
    return {f7[6:0], r2[4:0], r1[4:0], f3[2:0], rd[4:0], OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input int imm, input int r1, input int f3, input int rd, input logic [6:0] op);
    return {imm[11:0], r1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int r2, input int r1);
    return {imm[11:5], r2[4:0], r1[4:0], 3'b010, imm[4:0], OP_SW};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int r1, input int r2);
    return {imm[12], imm[10:5], r2[4:0], r1[4:0], 3'b000, imm[4:1], imm[11], OP_BEQ};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], OP_JAL};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] instr, input int w, input int cycles,
                              input bit has_wr, input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [31:0] next_pc);
    vec_t v;
    v.name = name; v.instr = instr; v.waits = w; v.cycles = cycles;
    v.has_wr = has_wr; v.waddr = waddr; v.wdata = wdata; v.next_pc = next_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One clock: choose mem_ready at the falling edge, sample, score the cycle.
  task automatic tick();
    wr_t w;
    @(negedge clk);
    if (mem_req) begin
      if (!in_txn) begin
        in_txn = 1'b1;
        wleft  = waits;
      end
      mem_ready = (wleft == 0);
      if (wleft > 0) wleft--;
    end else begin
      in_txn    = 1'b0;
      mem_ready = 1'b1;
    end
    #1;
    cyc++;
    if (prev_stall) begin
      chk("stall req/we hold", {30'd0, mem_req, mem_we}, snap_ctl);
      chk("stall addr hold", mem_addr, snap_addr);
      chk("stall wdata hold", mem_wdata, snap_wdata);
    end
    prev_stall = mem_req && !mem_ready;
    snap_ctl   = {30'd0, mem_req, mem_we};
    snap_addr  = mem_addr;
    snap_wdata = mem_wdata;
    if (mem_req && mem_ready) begin
      in_txn = 1'b0;
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected store: addr 0x%08h data 0x%08h, expected none", mem_addr, mem_wdata);
        end else begin
          w = wr_q.pop_front();
          chk("store addr", mem_addr, w.addr);
          chk("store data", mem_wdata, w.data);
        end
        mem[mem_addr[11:2]] = mem_wdata;
      end
    end
    if (retire) begin
      retired = 1'b1;
      if (ret_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected retire at cycle %0d, expected none", cyc);
      end else begin
        chk("retire cycle", cyc, ret_q.pop_front());
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    wr_t w;
    mem[exp_pc[11:2]] = v.instr;
    waits = v.waits;
    if (v.has_wr) begin
      w.addr = v.waddr;
      w.data = v.wdata;
      wr_q.push_back(w);
    end
    ret_q.push_back(cyc + v.cycles);
    retired = 1'b0;
    for (int k = 0; k < 40 && !retired; k++) tick();
    if (!retired) begin
      nvec++; nerr++;
      $display("FAIL %s timeout: no retire within 40 cycles, expected one", v.name);
      ret_q.delete();
    end
    @(posedge clk); #1;
    chk({v.name, " next pc"}, pc_out, v.next_pc);
    exp_pc = v.next_pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    nvec = 0; nerr = 0; cyc = 0; waits = 0; wleft = 0;
    in_txn = 1'b0; prev_stall = 1'b0; retired = 1'b0; exp_pc = 32'h0;
    snap_addr = '0; snap_wdata = '0; snap_ctl = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    reset = 1'b0;
    mem_ready = 1'b1;

    // x1=5 x2=7 x3=12, then a mixed program exercising every supported op.
    vecs.push_back(mk("addi x1",    enc_i(5, 0, 0, 1, OP_I),     0, 4,  0, 0, 0, 32'h04));
    vecs.push_back(mk("addi x2",    enc_i(7, 0, 0, 2, OP_I),     0, 4,  0, 0, 0, 32'h08));
    vecs.push_back(mk("add x3",     enc_r(0, 2, 1, 0, 3),        0, 4,  0, 0, 0, 32'h0C));
    vecs.push_back(mk("sw x3",      enc_s(32'h40, 3, 0),         0, 4,  1, 32'h40, 32'd12, 32'h10));
    vecs.push_back(mk("addi x0",    enc_i(9, 0, 0, 0, OP_I),     0, 4,  0, 0, 0, 32'h14));
    vecs.push_back(mk("sw x0",      enc_s(32'h44, 0, 0),         0, 4,  1, 32'h44, 32'd0, 32'h18));
    vecs.push_back(mk("lw x4 wait", enc_i(32'h40, 0, 2, 4, OP_LW), 3, 11, 0, 0, 0, 32'h1C));
    vecs.push_back(mk("sw x4 wait", enc_s(32'h48, 4, 0),         2, 8,  1, 32'h48, 32'd12, 32'h20));
    vecs.push_back(mk("beq taken",  enc_b(8, 1, 1),              0, 3,  0, 0, 0, 32'h28));
    vecs.push_back(mk("beq not",    enc_b(8, 1, 2),              0, 3,  0, 0, 0, 32'h2C));
    vecs.push_back(mk("jal x5",     enc_j(-8, 5),                0, 3,  0, 0, 0, 32'h24));
    vecs.push_back(mk("sw x5",      enc_s(32'h4C, 5, 0),         0, 4,  1, 32'h4C, 32'h30, 32'h28));
    vecs.push_back(mk("sub x6",     enc_r(32, 2, 1, 0, 6),       0, 4,  0, 0, 0, 32'h2C));
    vecs.push_back(mk("sw x6",      enc_s(32'h100, 6, 0),        0, 4,  1, 32'h100, 32'hFFFFFFFE, 32'h30));
    vecs.push_back(mk("slt x7",     enc_r(0, 1, 6, 2, 7),        0, 4,  0, 0, 0, 32'h34));
    vecs.push_back(mk("or x8",      enc_r(0, 6, 1, 6, 8),        0, 4,  0, 0, 0, 32'h38));
    vecs.push_back(mk("and x9",     enc_r(0, 2, 3, 7, 9),        0, 4,  0, 0, 0, 32'h3C));
    vecs.push_back(mk("slti x10",   enc_i(1, 6, 2, 10, OP_I),    0, 4,  0, 0, 0, 32'h40));
    vecs.push_back(mk("andi x11",   enc_i(32'hF0, 8, 7, 11, OP_I), 0, 4, 0, 0, 0, 32'h44));
    vecs.push_back(mk("ori x12",    enc_i(-16, 1, 6, 12, OP_I),  0, 4,  0, 0, 0, 32'h48));
    vecs.push_back(mk("sw x7",      enc_s(32'h104, 7, 0),        0, 4,  1, 32'h104, 32'd1, 32'h4C));
    vecs.push_back(mk("sw x8",      enc_s(32'h108, 8, 0),        0, 4,  1, 32'h108, 32'hFFFFFFFF, 32'h50));
    vecs.push_back(mk("sw x9",      enc_s(32'h10C, 9, 0),        0, 4,  1, 32'h10C, 32'd4, 32'h54));
    vecs.push_back(mk("sw x10",     enc_s(32'h110, 10, 0),       0, 4,  1, 32'h110, 32'd1, 32'h58));
    vecs.push_back(mk("sw x11",     enc_s(32'h114, 11, 0),       0, 4,  1, 32'h114, 32'hF0, 32'h5C));
    vecs.push_back(mk("sw x12",     enc_s(32'h118, 12, 0),       0, 4,  1, 32'h118, 32'hFFFFFFF5, 32'h60));

    // Reset window: no requests, no retire, not halted.
    repeat (3) begin
      @(negedge clk); #1;
      chk("reset mem_req", {31'd0, mem_req}, 32'd0);
      chk("reset halted/retire", {30'd0, halted, retire}, 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    cyc = 0;
    #1;
    chk("release pc_out", pc_out, 32'h0);
    chk("release req/we", {30'd0, mem_req, mem_we}, 32'd2);
    chk("release mem_addr", mem_addr, 32'h0);
    chk("release alu_result", alu_result, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      if (i == 0) chk("alu_result after addi", alu_result, 32'd5);
    end

    // Unsupported opcode: halt after DECODE, never request or retire again.
    mem[exp_pc[11:2]] = 32'h0000007F;
    waits = 0;
    tick();
    tick();
    chk("halted during decode", {31'd0, halted}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("trap halted", {31'd0, halted}, 32'd1);
      chk("trap no request", {31'd0, mem_req}, 32'd0);
    end
    chk("trap pc", pc_out, 32'h64);

    reset = 1'b0;
    prev_stall = 1'b0;
    in_txn = 1'b0;
    @(posedge clk); #1;
    chk("trap cleared by reset", {31'd0, halted}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc = 0;
    exp_pc = 32'h0;

    // Reset asserted while a store is stalled: the write must be abandoned.
    mem[0] = enc_s(32'h120, 1, 0);
    waits = 0;
    tick(); tick(); tick();
    waits = 10;
    tick();
    chk("memwrite req/we", {30'd0, mem_req, mem_we}, 32'd3);
    chk("memwrite addr", mem_addr, 32'h120);
    #1 reset = 1'b0;
    prev_stall = 1'b0;
    #1;
    chk("reset drops req", {30'd0, mem_req, mem_we}, 32'd0);
    repeat (2) begin
      tick();
      chk("req held off in reset", {31'd0, mem_req}, 32'd0);
    end
    waits = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    cyc = 0;
    #1;
    chk("restart req/we", {30'd0, mem_req, mem_we}, 32'd2);
    chk("restart mem_addr", mem_addr, 32'h0);
    chk("restart pc_out", pc_out, 32'h0);
    run_vec(mk("addi x13", enc_i(1, 0, 0, 13, OP_I), 0, 4, 0, 0, 0, 32'h04));
    run_vec(mk("sw x13",   enc_s(32'h11C, 13, 0),    0, 4, 1, 32'h11C, 32'd1, 32'h08));

    chk("pending stores", wr_q.size(), 32'd0);
    chk("pending retires", ret_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/processor_multicycle.md
Name: processor_multicycle

Overview:
- Parametrised multi-cycle RV32I-subset core. It is the successor to the single-cycle top level.
- Uses one shared instruction/data memory port with a req/ready handshake, so it tolerates wait states. Separate instruction and data memories with combinational reads are no longer required.
- A control FSM sequences the datapath. Architectural registers: PC, OldPC, IR, A, B, ALUOut, Data.
- Adds per-instruction retire reporting and a halting trap on unsupported opcodes.

Parameters:
- XLEN, 32, datapath/register/address width; must be >= 32. All immediates are sign-extended to XLEN.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_req  output  1  memory transaction request, held until accepted.
- mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  output  XLEN  byte address (word-aligned).
- mem_wdata  output  XLEN  store data (register B).
- mem_ready  input  1  memory accepts/completes the transaction this cycle.
- mem_rdata  input  XLEN  read data; valid in the cycle mem_ready=1 on a read.
- pc_out  output  XLEN  current PC register.
- alu_result  output  XLEN  ALUOut register.
- retire  output  1  one-cycle pulse when an instruction completes.
- halted  output  1  set when in TRAP.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; state=FETCH.
  - IR, A, B, ALUOut, Data, OldPC = 0.
  - retire=0, halted=0.
  - Register file is not cleared, except x0, which always reads 0.
- mem_req, mem_we and mem_addr decode combinationally from state only. Reset mid-transaction therefore drops mem_req in the same cycle, and the transaction is abandoned.
- Handshake:
  - A transaction completes on an edge where mem_req=1 and mem_ready=1.
  - While mem_ready=0, the state and all mem_* outputs hold stable.
  - mem_ready is ignored when mem_req=0.
- Supported instructions: lw, sw, R-type add/sub/and/or/slt, I-type addi/andi/ori/slti, beq, jal.
- States and transitions:
  - FETCH: req, addr=PC. On ready: IR<=rdata, OldPC<=PC, PC<=PC+4; go to DECODE.
  - DECODE: A<=rs1, B<=rs2, ALUOut<=OldPC+imm (B/J format per opcode). Next state by opcode: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, beq->BEQ, jal->JAL, other->TRAP.
  - MEMADR: ALUOut<=A+immI (immS for sw); go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: req, we=0, addr=ALUOut. On ready: Data<=rdata; go to MEMWB.
  - MEMWB: rd<=Data; retire; go to FETCH.
  - MEMWRITE: req, we=1, addr=ALUOut, wdata=B. On ready: retire; go to FETCH.
  - EXECR / EXECI: ALUOut<=A op B / A op immI; go to ALUWB.
  - ALUWB: rd<=ALUOut; retire; go to FETCH.
  - BEQ: if A==B then PC<=ALUOut; retire; go to FETCH.
  - JAL: rd<=OldPC+4, PC<=ALUOut; retire; go to FETCH.
  - TRAP: halted=1, no memory requests; stays here until reset.
- Zero-wait cycle counts: lw 5, sw 4, R 4, I 4, beq 3, jal 3. Each wait cycle adds 1 per memory state.
- Writes to rd=x0 are discarded.
- Arithmetic wraps modulo 2^XLEN. slt/slti compare signed.
- PC+4 wraps modulo 2^XLEN.
- Misaligned addresses are not checked; mem_addr passes through unmodified.

Decomposition:
- Shared header riscv_defs.vh holds:
  - opcode constants (LW=0000011, SW=0100011, R=0110011, I=0010011, BEQ=1100011, JAL=1101111);
  - FSM state encodings;
  - ALUControl codes (the existing 3-bit encoding);
  - ImmSrc codes.
- One natural sub-module: multicycle_control. It contains the FSM and emits datapath enables/selects.
- The existing alu_decoder is reused inside multicycle_control. The datapath (extend, ALU, register file) is widened to XLEN within processor_multicycle.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release with RESET_PC=0 and mem_ready=1. Required: pc_out=0, mem_req=1, mem_addr=0 in the first cycle after release. Without reset, mem_req stays 0 throughout the reset window.
- ALU and x0 discard: run addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sw x3,0x40(x0). Required: write of 12 at address 0x40 with mem_we=1, and retire pulses at cycles 4, 8, 12, 16. addi x0,x0,9 followed by sw x0 stores 0.
- Wait states on load: lw x4,0x40(x0) with mem_ready=0 for 3 cycles during both FETCH and MEMREAD. Required: outputs stable while stalled, x4=12, total 11 cycles to retire.
- Branches and jump: beq x1,x1,+8 makes PC skip one instruction (3 cycles). beq x1,x2 falls through to PC+4. jal x5,-8 gives x5=OldPC+4 and PC=OldPC-8.
- Illegal opcode: opcode 0x7F. Required: halted=1 after DECODE, mem_req=0 forever, no retire, until reset=0.
- Reset mid-operation: assert reset during MEMWRITE with mem_ready=0. Required: mem_req drops immediately, no write occurs, and the next request after release is FETCH at RESET_PC.
